// File: rtl/sobel_window_ctrl_pkg.sv
// Shared definitions for the Sobel window controller and its raster counter.
// State encodings are plain constants so older tools can consume them.
package sobel_window_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FILL  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_COL_W = $clog2(DEF_IMG_W);
  localparam int DEF_ROW_W = $clog2(DEF_IMG_H);

endpackage

// File: rtl/sobel_window_ctrl_raster_counter.sv
// Column/row raster position counter with wrap, restart and frame-edge detect.
// Holds the position of the next pixel to be accepted.
module sobel_window_ctrl_raster_counter
  import sobel_window_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             restart,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             at_first,
  output logic             at_last
);

  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic             col_end_s;
  logic             row_end_s;

  assign col_end_s = (col_r == COL_W'(IMG_W - 1));
  assign row_end_s = (row_r == ROW_W'(IMG_H - 1));

  // restart means the current pixel is taken as (0,0), so the next one is (0,1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= COL_W'(0);
      row_r <= ROW_W'(0);
    end else if (restart) begin
      col_r <= COL_W'(1);
      row_r <= ROW_W'(0);
    end else if (inc) begin
      if (col_end_s) begin
        col_r <= COL_W'(0);
        row_r <= row_end_s ? ROW_W'(0) : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
        row_r <= row_r;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  assign col      = col_r;
  assign row      = row_r;
  assign at_first = (col_r == COL_W'(0)) && (row_r == ROW_W'(0));
  assign at_last  = col_end_s && row_end_s;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequencing controller for the Sobel 3x3 window datapath: handshake, chain
// clock enable, window-complete flag with centre position, and frame sync.
module sobel_window_ctrl
  import sobel_window_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int WIDTH = 8,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] sr_d,
  output logic             sr_ce,
  output logic             win_valid,
  input  logic             m_ready,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             frame_done,
  output logic             sync_err
);

  state_t           state_r, state_nx;
  logic             win_valid_r, win_valid_nx;
  logic [COL_W-1:0] win_col_r, win_col_nx;
  logic [ROW_W-1:0] win_row_r, win_row_nx;
  logic             frame_done_r, frame_done_nx;
  logic             sync_err_r, sync_err_nx;

  logic             acc_s, in_frame_s, start_s, stray_s, resync_s;
  logic             pix_in_s, complete_s, consume_s;
  logic [COL_W-1:0] col_s;
  logic [ROW_W-1:0] row_s;
  logic             at_first_s, at_last_s;

  assign s_ready    = (state_r != ST_DONE) && (m_ready || !win_valid_r);
  assign acc_s      = s_valid && s_ready;
  assign in_frame_s = (state_r == ST_FILL) || (state_r == ST_RUN);
  assign start_s    = acc_s && s_sof && (state_r == ST_IDLE);
  assign stray_s    = acc_s && !s_sof && (state_r == ST_IDLE);
  assign resync_s   = acc_s && s_sof && in_frame_s && !at_first_s;
  assign pix_in_s   = acc_s && in_frame_s && !resync_s;
  assign complete_s = pix_in_s && (row_s >= ROW_W'(2)) && (col_s >= COL_W'(2));
  assign consume_s  = m_ready || !win_valid_r;

  // Stray pixels before a start-of-frame never reach the shift registers
  assign sr_ce = acc_s && !stray_s;
  assign sr_d  = s_data;

  sobel_window_ctrl_raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_raster (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pix_in_s),
    .restart  (start_s || resync_s),
    .col      (col_s),
    .row      (row_s),
    .at_first (at_first_s),
    .at_last  (at_last_s)
  );

  // Frame sequencing
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nx = ST_FILL;
        else         state_nx = ST_IDLE;
      end
      ST_FILL: begin
        if (resync_s)                    state_nx = ST_FILL;
        else if (pix_in_s && at_last_s)  state_nx = ST_DRAIN;
        else if (complete_s)             state_nx = ST_RUN;
        else                             state_nx = ST_FILL;
      end
      ST_RUN: begin
        if (resync_s)                    state_nx = ST_FILL;
        else if (pix_in_s && at_last_s)  state_nx = ST_DRAIN;
        else                             state_nx = ST_RUN;
      end
      ST_DRAIN: begin
        if (consume_s) state_nx = ST_DONE;
        else           state_nx = ST_DRAIN;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // A new window may replace the one being consumed on the same edge
  always_comb begin
    win_valid_nx = win_valid_r;
    win_col_nx   = win_col_r;
    win_row_nx   = win_row_r;
    if (complete_s) begin
      win_valid_nx = 1'b1;
      win_col_nx   = col_s - COL_W'(1);
      win_row_nx   = row_s - ROW_W'(1);
    end else if (resync_s) begin
      win_valid_nx = 1'b0;
    end else if (m_ready) begin
      win_valid_nx = 1'b0;
    end else begin
      win_valid_nx = win_valid_r;
    end
    frame_done_nx = (state_r == ST_DRAIN) && consume_s;
    sync_err_nx   = sync_err_r || stray_s || resync_s;
  end

  // Controller state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      win_valid_r  <= 1'b0;
      win_col_r    <= COL_W'(0);
      win_row_r    <= ROW_W'(0);
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      state_r      <= state_nx;
      win_valid_r  <= win_valid_nx;
      win_col_r    <= win_col_nx;
      win_row_r    <= win_row_nx;
      frame_done_r <= frame_done_nx;
      sync_err_r   <= sync_err_nx;
    end
  end

  assign win_valid  = win_valid_r;
  assign win_col    = win_col_r;
  assign win_row    = win_row_r;
  assign frame_done = frame_done_r;
  assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on a 5x4 image, with a window
// scoreboard filled from the bench's own raster model of the pixels it sends.
module tb_sobel_window_ctrl;

  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int WIDTH = 8;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } win_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic             s_sof;
  logic [WIDTH-1:0] s_data;
  logic [WIDTH-1:0] sr_d;
  logic             sr_ce;
  logic             win_valid;
  logic             m_ready;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;
  logic             frame_done;
  logic             sync_err;

  int   n_checks = 0;
  int   n_fail = 0;
  win_t exp_q[$];
  win_t exp_w;
  int   win_cnt = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_hs_cyc = -10;
  int   px_col = 0;
  int   px_row = 0;

  always #5 clk = ~clk;

  sobel_window_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sof      (s_sof),
    .s_data     (s_data),
    .sr_d       (sr_d),
    .sr_ce      (sr_ce),
    .win_valid  (win_valid),
    .m_ready    (m_ready),
    .win_col    (win_col),
    .win_row    (win_row),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  // Window monitor: pops the scoreboard on every window handshake
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst_n === 1'b1 && win_valid === 1'b1 && m_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL window_unexpected: got row=%0d col=%0d, required no window", win_row, win_col);
      end else begin
        exp_w = exp_q.pop_front();
        if (win_row !== exp_w.row || win_col !== exp_w.col) begin
          n_fail++;
          $display("FAIL window_pos: got row=%0d col=%0d, required row=%0d col=%0d",
                   win_row, win_col, exp_w.row, exp_w.col);
        end
      end
      win_cnt++;
      last_hs_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      n_checks++;
      if (cyc != last_hs_cyc + 1 || s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_done_timing: got %0d cycles after last window with s_ready=%b, required 1 cycle with s_ready=0",
                 cyc - last_hs_cyc, s_ready);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (win_valid !== 1'b0 || s_ready !== 1'b1 || win_col !== 3'd0 || win_row !== 2'd0 ||
        frame_done !== 1'b0 || sync_err !== 1'b0 || sr_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got win_valid=%b s_ready=%b win_col=%0d win_row=%0d frame_done=%b sync_err=%b sr_ce=%b, required 0 1 0 0 0 0 0",
               tag, win_valid, s_ready, win_col, win_row, frame_done, sync_err, sr_ce);
    end
  endtask

  task automatic send_px(input logic sof, input logic discard);
    logic [WIDTH-1:0] d;
    int budget;
    win_t w;
    d = WIDTH'($urandom);
    @(negedge clk);
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = d;
    #1;
    budget = 0;
    while (s_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: got s_ready=%b after %0d cycles, required 1", s_ready, budget);
      s_valid = 1'b0;
      return;
    end
    n_checks++;
    if (sr_ce !== !discard) begin
      n_fail++;
      $display("FAIL sr_ce_on_accept: got %b, required %b", sr_ce, !discard);
    end
    n_checks++;
    if (sr_d !== d) begin
      n_fail++;
      $display("FAIL sr_d: got %h, required %h", sr_d, d);
    end
    if (!discard) begin
      if (sof) begin
        px_col = 0;
        px_row = 0;
      end
      if (px_row >= 2 && px_col >= 2) begin
        w.row = ROW_W'(px_row - 1);
        w.col = COL_W'(px_col - 1);
        exp_q.push_back(w);
      end
      px_col++;
      if (px_col == IMG_W) begin
        px_col = 0;
        px_row = (px_row + 1) % IMG_H;
      end
    end
    @(posedge clk);
  endtask

  task automatic gap_cycle();
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    #1;
    n_checks++;
    if (sr_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL sr_ce_gap: got %b, required 0", sr_ce);
    end
  endtask

  task automatic stall3();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_sof   = 1'b0;
      #1;
      n_checks++;
      if (s_ready !== 1'b0 || sr_ce !== 1'b0 || win_valid !== 1'b1 ||
          win_col !== 3'd1 || win_row !== 2'd1) begin
        n_fail++;
        $display("FAIL stall_hold: got s_ready=%b sr_ce=%b win_valid=%b col=%0d row=%0d, required 0 0 1 1 1",
                 s_ready, sr_ce, win_valid, win_col, win_row);
      end
    end
    @(negedge clk);
    m_ready = 1'b1;
    s_valid = 1'b0;
  endtask

  task automatic finish_frame(input int exp_windows);
    int start_done;
    int budget;
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    start_done = done_cnt;
    budget = 0;
    while (done_cnt == start_done && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    n_checks++;
    if (done_cnt != start_done + 1) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d pulses, required 1", done_cnt - start_done);
    end
    n_checks++;
    if (win_cnt != exp_windows || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL window_count: got %0d windows with %0d still expected, required %0d and 0",
               win_cnt, exp_q.size(), exp_windows);
    end
  endtask

  task automatic send_frame(input int gap_pct, input int stall_idx);
    win_cnt = 0;
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) gap_cycle();
      send_px(i == 0, 1'b0);
      if (i == stall_idx) stall3();
    end
    finish_frame((IMG_H - 2) * (IMG_W - 2));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    send_frame(0, -1);
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_err_clean: got %b, required 0", sync_err);
    end
  endtask

  task automatic test_stall();
    send_frame(0, 2 * IMG_W + 2);
  endtask

  task automatic test_gaps();
    send_frame(50, -1);
  endtask

  task automatic test_resync();
    win_cnt = 0;
    for (int i = 0; i < IMG_W + 3; i++) send_px(i == 0, 1'b0);
    for (int i = 0; i < IMG_W * IMG_H; i++) send_px(i == 0, 1'b0);
    finish_frame((IMG_H - 2) * (IMG_W - 2));
    n_checks++;
    if (sync_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_err_resync: got %b, required 1", sync_err);
    end
  endtask

  task automatic test_idle_stray();
    pulse_reset();
    for (int i = 0; i < 3; i++) send_px(1'b0, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    n_checks++;
    if (sync_err !== 1'b1 || win_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_stray: got sync_err=%b win_valid=%b, required 1 0", sync_err, win_valid);
    end
    send_frame(0, -1);
  endtask

  task automatic test_reset_mid();
    win_cnt = 0;
    for (int i = 0; i < 3 * IMG_W; i++) send_px(i == 0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (win_cnt != 3) begin
      n_fail++;
      $display("FAIL windows_before_reset: got %0d, required 3", win_cnt);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset_mid_run");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, -1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_gaps();
    test_resync();
    test_idle_stray();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Sequencing controller for the Sobel 3x3 window datapath. It accepts a raster pixel stream over a valid/ready handshake and drives the common clock enable of the line-buffer and tap shift-register chain. It tracks column and row position and flags when the 3x3 window at the shift-register outputs is complete and usable. It sits between the pixel source and the shift-register/convolution datapath, and applies downstream backpressure by freezing the chain.

## Interface
- IMG_W, 640: pixels per line; minimum 3.
- IMG_H, 480: lines per frame; minimum 3.
- WIDTH, 8: pixel width; data passes straight through.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  source pixel valid.
- s_ready  out  1  controller can accept a pixel.
- s_sof  in  1  start of frame; qualified by s_valid, marks pixel (0,0).
- s_data  in  WIDTH  source pixel.
- sr_d  out  WIDTH  data to the shift-register chain; equals s_data.
- sr_ce  out  1  clock enable to every shift register in the chain.
- win_valid  out  1  3x3 window at the chain outputs is complete.
- m_ready  in  1  downstream consumes the window this cycle.
- win_col  out  $clog2(IMG_W)  column of the window centre.
- win_row  out  $clog2(IMG_H)  row of the window centre.
- frame_done  out  1  one-cycle pulse after the last window of a frame is consumed.
- sync_err  out  1  sticky; set when s_sof arrives in an unexpected position; cleared by reset.

## Operation
- Accept: acc = s_valid & s_ready. sr_ce = acc, combinational. sr_d = s_data.
- s_ready = (state != DONE) & (m_ready | ~win_valid). A stalled window freezes the chain.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) count accepted pixels:
  - col increments on each acc.
  - When col = IMG_W-1, col wraps to 0 and row increments.
- A window is complete when the accepted pixel has row >= 2 and col >= 2.
- Window-centre position: win_col = col-1 and win_row = row-1 of the completing pixel. Both are registered.
- The window does not wrap horizontally. Centres at col 0 or IMG_W-1, or at row 0 or IMG_H-1, are never flagged.
- States:
  - IDLE: waits for acc & s_sof. That pixel is loaded as (0,0) and the state moves to FILL. In IDLE, a pixel accepted without s_sof is discarded: sr_ce stays 0 and sync_err is set.
  - FILL: runs until the first complete window, at pixel (2,2). Then goes to RUN.
  - RUN: runs until the pixel at (IMG_H-1, IMG_W-1) is accepted. Then goes to DRAIN.
  - DRAIN: waits until the final win_valid is consumed (m_ready). Then goes to DONE.
  - DONE: one cycle. Pulses frame_done, then returns to IDLE.
- s_sof in FILL or RUN at a position other than (0,0):
  - sync_err is set.
  - Counters reload to (0,0) and the state moves to FILL.
  - A pending win_valid is dropped.
- Reset values: state IDLE; col = row = 0; win_valid = 0; win_col = win_row = 0; frame_done = 0; sync_err = 0; s_ready = 1.

## Timing
- win_valid rises on the clock edge that accepts the completing pixel. This is the same edge on which the shift registers capture it, so the window and the flag align.
- Next-state rule for win_valid:
  - If acc and the pixel completes a window, win_valid becomes 1.
  - Otherwise, if m_ready, win_valid becomes 0.
  - Otherwise it holds.
- With s_valid and m_ready held high, throughput is one pixel per clock.
- Per frame: (IMG_H-2)*(IMG_W-2) windows.
- frame_done occurs 1 cycle after the final window handshake. s_ready is 0 during DONE.
- If acc and m_ready occur together while win_valid=1, the old window is consumed and the new one is loaded on the same edge. There is no bubble.
- rst_n asserted mid-frame clears all state immediately. The next frame must start with s_sof.

## Structure
- Shared package holds:
  - State enum {IDLE, FILL, RUN, DRAIN, DONE}.
  - Helper constants COL_W = $clog2(IMG_W) and ROW_W = $clog2(IMG_H).
- One natural sub-module: raster_counter. It is the col/row counter with wrap, load-to-zero and end-of-frame detect, reusable by the Sobel output stage.
- The controller itself contains the FSM, the win_valid register and the handshake logic.

## Test plan
- IMG_W=5, IMG_H=4, s_valid and m_ready always 1 -> 6 win_valid pulses:
  - win_row=1 with win_col=1,2,3, then win_row=2 with win_col=1,2,3.
  - frame_done 1 cycle after the last one.
- Same frame with m_ready=0 for 3 cycles at the first window -> s_ready=0 and sr_ce=0 for those 3 cycles; win_col/win_row stay at (1,1); no pixel is lost.
- Random s_valid gaps (50%) -> window positions and count are identical to the first scenario; sr_ce is 1 only on accepted pixels.
- s_sof at pixel (1,3) of a frame -> sync_err=1; counters restart; the next 6 windows are counted from that pixel as (0,0).
- Pixels without s_sof while in IDLE -> sr_ce stays 0 and sync_err=1; a subsequent s_sof frame processes normally.
- rst_n low for 1 cycle in mid-RUN -> all outputs return to reset values asynchronously; a following clean frame yields 6 windows.
